// File: rtl/cache_ctrl_fsm.sv
// cache_ctrl_fsm: 4-line x 4-word direct-mapped write-back data cache controller (tag[9:6] idx[5:4] word[3:2]).
// Latency: hit ready 2 cycles after acceptance; clean miss 4+Lr; dirty miss 5+Lw+Lr (L = cycles mem_req high incl. ack).
// Backpressure: one access in flight, cpu_req sampled only in IDLE; memory side holds req/we/addr/wdata until mem_ack.
// Ports: clk/rst_n (sync, active-low); cpu_req/we/addr/wdata in, cpu_rdata/ready/hit out;
//        mem_req/we/addr/wdata out, mem_rdata/ack in; mem_err sticky timeout flag.
// Optional: define CACHE_STATS_EN to add saturating stat_hits/stat_misses/stat_wbacks counters.
module cache_ctrl_fsm #(
    parameter int MEM_TIMEOUT = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         cpu_req,
    input  logic         cpu_we,
    input  logic [9:0]   cpu_addr,
    input  logic [31:0]  cpu_wdata,
    output logic [31:0]  cpu_rdata,
    output logic         cpu_ready,
    output logic         cpu_hit,
    output logic         mem_req,
    output logic         mem_we,
    output logic [9:0]   mem_addr,
    output logic [127:0] mem_wdata,
    input  logic [127:0] mem_rdata,
    input  logic         mem_ack,
    output logic         mem_err
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]  stat_hits,
    output logic [15:0]  stat_misses,
    output logic [15:0]  stat_wbacks
`endif
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPARE,
        S_WRITEBACK,
        S_ALLOCATE
    } state_t;

    localparam int            TW       = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t        state, state_nxt;
    logic          req_we;
    logic [9:2]    req_addr;
    logic [31:0]   req_wdata;
    logic          miss_flag;
    logic [3:0]    valid, dirty;
    logic [3:0]    tag_arr  [4];
    logic [127:0]  data_arr [4];
    logic [TW-1:0] tmo_cnt;

    logic [1:0]    idx, word;
    logic [3:0]    tag;
    logic [127:0]  cur_line;
    logic          hit, ack_ok, timeout, fill, wr_hit;
    logic          unused_addr_lsbs;

    assign unused_addr_lsbs = ^cpu_addr[1:0];

    assign idx      = req_addr[5:4];
    assign word     = req_addr[3:2];
    assign tag      = req_addr[9:6];
    assign cur_line = data_arr[idx];
    assign hit      = valid[idx] && (tag_arr[idx] == tag);
    // acks are only meaningful while a request is outstanding
    assign ack_ok   = mem_req && mem_ack;
    assign timeout  = (MEM_TIMEOUT > 0) && mem_req && !mem_ack && (tmo_cnt == TMO_LAST);
    assign fill     = (state == S_ALLOCATE) && ack_ok;
    assign wr_hit   = (state == S_COMPARE) && hit && req_we;

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:      if (cpu_req) state_nxt = S_COMPARE;
            S_COMPARE:   if (hit)              state_nxt = S_IDLE;
                         else if (dirty[idx])  state_nxt = S_WRITEBACK;
                         else                  state_nxt = S_ALLOCATE;
            S_WRITEBACK: if (timeout)     state_nxt = S_IDLE;
                         else if (ack_ok) state_nxt = S_ALLOCATE;
            S_ALLOCATE:  if (timeout)     state_nxt = S_IDLE;
                         else if (ack_ok) state_nxt = S_COMPARE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            valid     <= '0;
            dirty     <= '0;
            cpu_rdata <= '0;
            cpu_ready <= 1'b0;
            cpu_hit   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_err   <= 1'b0;
            req_we    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            miss_flag <= 1'b0;
            tmo_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            cpu_ready <= 1'b0;
            cpu_hit   <= 1'b0;
            // counts cycles the current request has been waiting
            tmo_cnt   <= (mem_req && !mem_ack) ? tmo_cnt + TW'(1) : '0;
            unique case (state)
                S_IDLE: if (cpu_req) begin
                    req_we    <= cpu_we;
                    req_addr  <= cpu_addr[9:2];
                    req_wdata <= cpu_wdata;
                    miss_flag <= 1'b0;
                end
                S_COMPARE: if (hit) begin
                    cpu_ready <= 1'b1;
                    cpu_hit   <= !miss_flag;
                    if (req_we) dirty[idx] <= 1'b1;
                    else        cpu_rdata  <= cur_line[{word, 5'd0} +: 32];
                end else begin
                    miss_flag <= 1'b1;
                end
                // Request is raised one cycle after entering the state, which also
                // guarantees a low cycle between the write-back and allocate requests.
                S_WRITEBACK: if (!mem_req) begin
                    mem_req   <= 1'b1;
                    mem_we    <= 1'b1;
                    mem_addr  <= {tag_arr[idx], idx, 4'b0};
                    mem_wdata <= cur_line;
                end else if (ack_ok) begin
                    mem_req    <= 1'b0;
                    dirty[idx] <= 1'b0;
                end else if (timeout) begin
                    mem_req   <= 1'b0;
                    mem_err   <= 1'b1;
                    cpu_ready <= 1'b1;
                    cpu_rdata <= '0;
                end
                S_ALLOCATE: if (!mem_req) begin
                    mem_req  <= 1'b1;
                    mem_we   <= 1'b0;
                    mem_addr <= {req_addr[9:4], 4'b0};
                end else if (ack_ok) begin
                    mem_req    <= 1'b0;
                    valid[idx] <= 1'b1;
                    dirty[idx] <= 1'b0;
                end else if (timeout) begin
                    mem_req    <= 1'b0;
                    mem_err    <= 1'b1;
                    cpu_ready  <= 1'b1;
                    cpu_rdata  <= '0;
                    valid[idx] <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Tag/data storage carries no reset; valid bits qualify its contents.
    always_ff @(posedge clk) begin
        if (fill) begin
            data_arr[idx] <= mem_rdata;
            tag_arr[idx]  <= tag;
        end else if (wr_hit) begin
            data_arr[idx][{word, 5'd0} +: 32] <= req_wdata;
        end
    end

`ifdef CACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_hits   <= '0;
            stat_misses <= '0;
            stat_wbacks <= '0;
        end else begin
            if (cpu_ready && cpu_hit && stat_hits != 16'hFFFF)
                stat_hits <= stat_hits + 16'd1;
            if (cpu_ready && !cpu_hit && stat_misses != 16'hFFFF)
                stat_misses <= stat_misses + 16'd1;
            if (state == S_WRITEBACK && ack_ok && stat_wbacks != 16'hFFFF)
                stat_wbacks <= stat_wbacks + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// tb_cache_ctrl_fsm: scoreboard bench for cache_ctrl_fsm with a behavioural line memory.
// Latency: n/a (bench).
// Backpressure: memory model acks after a programmable number of request cycles.
`timescale 1ns/1ps
module tb_cache_ctrl_fsm;
    localparam int TMO = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         cpu_req, cpu_we;
    logic [9:0]   cpu_addr;
    logic [31:0]  cpu_wdata, cpu_rdata;
    logic         cpu_ready, cpu_hit;
    logic         mem_req, mem_we, mem_ack, mem_err;
    logic [9:0]   mem_addr;
    logic [127:0] mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    cache_ctrl_fsm #(.MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .cpu_hit(cpu_hit),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .mem_err(mem_err)
    );

    typedef struct { logic hit; logic [31:0] rdata; logic chk_rd; } cpu_exp_t;
    typedef struct { logic we; logic [9:0] addr; logic [127:0] wdata; } mem_exp_t;

    cpu_exp_t     exp_q[$];
    mem_exp_t     mexp_q[$];
    int           n_cmp = 0, n_bad = 0;
    logic [127:0] mem_arr [64];
    logic [127:0] ref_mem [64];
    logic [3:0]   m_valid, m_dirty;
    logic [3:0]   m_tag  [4];
    logic [127:0] m_line [4];
    int           ack_lat = 3, ack_hold = 0;
    bit           mem_mute = 0, spur = 0;
    int           hi_cnt = 0, hold_left = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] init_line(input int l);
        logic [127:0] v;
        for (int j = 0; j < 4; j++) v[j*32 +: 32] = 32'hA500_0000 | (32'(l) << 8) | 32'(j);
        return v;
    endfunction

    task automatic model_reset();
        m_valid = '0;
        m_dirty = '0;
        exp_q.delete();
        mexp_q.delete();
    endtask

    // Transaction-level cache model: pushes expected memory traffic and CPU result.
    task automatic predict(input logic we, input logic [9:0] a, input logic [31:0] wd, output int lat);
        logic [1:0] ix, w;
        logic [3:0] tg;
        cpu_exp_t   e;
        mem_exp_t   m;
        ix = a[5:4]; w = a[3:2]; tg = a[9:6];
        if (m_valid[ix] && m_tag[ix] == tg) begin
            lat = 1; e.hit = 1'b1;
        end else begin
            e.hit = 1'b0;
            if (mem_mute) begin
                lat = 2 + TMO;
                if (!m_dirty[ix]) m_valid[ix] = 1'b0;
                e.rdata = '0; e.chk_rd = 1'b1;
                exp_q.push_back(e);
                return;
            end
            if (m_dirty[ix]) begin
                m.we = 1'b1; m.addr = {m_tag[ix], ix, 4'b0}; m.wdata = m_line[ix];
                mexp_q.push_back(m);
                ref_mem[{m_tag[ix], ix}] = m_line[ix];
                lat = 4 + 2 * ack_lat;
            end else begin
                lat = 3 + ack_lat;
            end
            m.we = 1'b0; m.addr = {a[9:4], 4'b0}; m.wdata = '0;
            mexp_q.push_back(m);
            m_line[ix] = ref_mem[a[9:4]];
            m_tag[ix] = tg; m_valid[ix] = 1'b1; m_dirty[ix] = 1'b0;
        end
        if (we) begin
            m_line[ix][w*32 +: 32] = wd;
            m_dirty[ix] = 1'b1;
            e.rdata = '0; e.chk_rd = 1'b0;
        end else begin
            e.rdata = m_line[ix][w*32 +: 32]; e.chk_rd = 1'b1;
        end
        exp_q.push_back(e);
    endtask

    // Called in the #1-after-edge phase; returns in the cycle cpu_ready is high.
    task automatic access(input logic we, input logic [9:0] a, input logic [31:0] wd,
                          input bit toggle, input string tag, output int nreq);
        int lat, k;
        predict(we, a, wd, lat);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_we = 1'($urandom); cpu_addr = 10'($urandom); cpu_wdata = $urandom;
        k = 0; nreq = 0;
        while (!cpu_ready && k < 100) begin
            if (mem_req) nreq++;
            if (toggle) cpu_req = ~cpu_req;
            @(posedge clk); #1;
            k++;
        end
        cpu_req = 1'b0;
        chk({tag, "_latency"}, k, lat);
    endtask

    // Memory responder + memory-side scoreboard.
    initial begin
        mem_exp_t e;
        mem_ack = 1'b0; mem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst_n || !mem_req) hi_cnt = 0; else hi_cnt++;
            if (mem_req && !mem_mute && hi_cnt == ack_lat) begin
                mem_ack = 1'b1; hold_left = ack_hold;
                if (mexp_q.size() == 0) chk("mem_unexpected", 1, 0);
                else begin
                    e = mexp_q.pop_front();
                    chk("mem_we", mem_we, e.we);
                    chk("mem_addr", mem_addr, e.addr);
                    if (e.we) chk("mem_wdata", mem_wdata, e.wdata);
                end
                if (mem_we) mem_arr[mem_addr[9:4]] = mem_wdata;
                else        mem_rdata = mem_arr[mem_addr[9:4]];
            end else if (hold_left > 0) begin
                mem_ack = 1'b1; hold_left--;
            end else if (spur) begin
                mem_ack = 1'b1;
            end else begin
                mem_ack = 1'b0;
            end
        end
    end

    // CPU-side scoreboard.
    initial begin
        cpu_exp_t ce;
        forever begin
            @(posedge clk); #1;
            if (cpu_ready) begin
                if (exp_q.size() == 0) chk("ready_unexpected", 1, 0);
                else begin
                    ce = exp_q.pop_front();
                    chk("cpu_hit", cpu_hit, ce.hit);
                    if (ce.chk_rd) chk("cpu_rdata", cpu_rdata, ce.rdata);
                end
            end
        end
    end

    initial begin
        int n, k;
        for (int l = 0; l < 64; l++) begin
            mem_arr[l] = init_line(l);
            ref_mem[l] = init_line(l);
        end
        rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cpu_ready", cpu_ready, 0);
        chk("rst_cpu_hit",   cpu_hit,   0);
        chk("rst_cpu_rdata", cpu_rdata, 0);
        chk("rst_mem_req",   mem_req,   0);
        chk("rst_mem_we",    mem_we,    0);
        chk("rst_mem_addr",  mem_addr,  0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_err",   mem_err,   0);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;

        // clean read miss, then back-to-back hit
        ack_lat = 3;
        access(1'b0, 10'h044, '0, 1'b0, "rd_miss_044", n);
        access(1'b0, 10'h048, '0, 1'b0, "rd_hit_048", n);
        chk("hit_048_no_mem", n, 0);
        // write hit, then dirty conflict miss
        access(1'b1, 10'h04C, 32'hDEADBEEF, 1'b0, "wr_hit_04C", n);
        chk("hit_04C_no_mem", n, 0);
        access(1'b0, 10'h24C, '0, 1'b0, "rd_dirty_24C", n);
        // write miss to clean line, then conflicting read writes it back
        access(1'b1, 10'h3F0, 32'h12345678, 1'b0, "wr_miss_3F0", n);
        access(1'b0, 10'h030, '0, 1'b0, "rd_dirty_030", n);

        // ack held 3 cycles, cpu_req toggled mid-miss
        ack_lat = 2; ack_hold = 2;
        access(1'b0, 10'h1A4, '0, 1'b1, "rd_hold_1A4", n);
        ack_hold = 0;
        repeat (3) @(posedge clk);
        @(negedge clk); spur = 1'b1;
        @(negedge clk); spur = 1'b0;
        @(posedge clk); #1;
        chk("spur_mem_req", mem_req, 0);
        access(1'b0, 10'h1A8, '0, 1'b0, "rd_hit_1A8", n);
        chk("hit_1A8_no_mem", n, 0);
        ack_lat = 1;
        access(1'b0, 10'h110, '0, 1'b0, "rd_ack1_110", n);

        // reset while an allocate waits on memory
        ack_lat = 6;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h2D4; cpu_wdata = '0;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        k = 0;
        while (!mem_req && k < 20) begin @(posedge clk); #1; k++; end
        chk("alloc_2D4_req", mem_req, 1);
        chk("alloc_2D4_addr", mem_addr, 10'h2D0);
        chk("alloc_2D4_we", mem_we, 0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_mem_req", mem_req, 0);
        chk("midrst_cpu_ready", cpu_ready, 0);
        rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("midrst_no_ready", cpu_ready, 0);
        end
        ack_lat = 2;
        access(1'b0, 10'h110, '0, 1'b0, "rd_after_rst_110", n);

        // memory never answers
        mem_mute = 1'b1;
        access(1'b0, 10'h0C0, '0, 1'b0, "tmo_0C0", n);
        chk("tmo_req_cycles", n, TMO);
        chk("tmo_mem_err", mem_err, 1);
        mem_mute = 1'b0;
        @(posedge clk); #1;
        chk("tmo_mem_req_low", mem_req, 0);
        repeat (3) @(posedge clk);
        #1;
        access(1'b0, 10'h0C0, '0, 1'b0, "rd_after_tmo_0C0", n);
        chk("mem_err_sticky", mem_err, 1);

        repeat (5) @(posedge clk);
        #1;
        chk("cpu_exp_drained", exp_q.size(), 0);
        chk("mem_exp_drained", mexp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
